occupancy_ctrl: RTL



---
 rtl/occ_pkg.sv | 21 ++
 rtl/occ_sync.sv | 24 ++
 rtl/occupancy_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/occ_pkg.sv
// Shared constants for the gate occupancy controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package occ_pkg;

  // Sequencer state encoding, {a,b} progress through an entry or an exit.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EN1  = 3'd1;  // A only
  localparam logic [2:0] ST_EN2  = 3'd2;  // both
  localparam logic [2:0] ST_EN3  = 3'd3;  // B only
  localparam logic [2:0] ST_EX1  = 3'd4;  // B only
  localparam logic [2:0] ST_EX2  = 3'd5;  // both
  localparam logic [2:0] ST_EX3  = 3'd6;  // A only

  localparam int OCC_CAPACITY_DEF = 15;
  localparam int OCC_TIMEOUT_DEF  = 255;

  // Width of the in-state dwell counter used for the sequence timeout.
  localparam int TMO_W = 8;

endpackage

// File: rtl/occ_sync.sv
// Two-flop synchronizer for one asynchronous sensor bit.
// Latency: 2 clk cycles.
// Backpressure: none; free-running, both flops reset to 0.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module occ_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/occupancy_ctrl.sv
// Entry/exit sequencer for a two-beam gate; drives add/delete/load pulses and a shadow count.
// Latency: commit pulse and count update 1 cycle after the final 00 is sampled (+2 with OCC_CTRL_SYNC_EN).
// Backpressure: none; entries refused at CAPACITY and exits at zero are flagged with reject.
// Ports: clk, rst_n, sens_a (outer beam), sens_b (inner beam), clear (operator zero);
//        add/delete/load counter pulses, occupancy, full, empty, gate_open, reject, abort.
// Build option: define OCC_CTRL_SYNC_EN to pass both sensors through 2-flop synchronizers.
module occupancy_ctrl
  import occ_pkg::*;
#(
  parameter int CAPACITY = OCC_CAPACITY_DEF,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = OCC_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sens_a,
  input  logic             sens_b,
  input  logic             clear,
  output logic             add,
  output logic             delete,
  output logic             load,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             reject,
  output logic             abort
);

  logic a_s, b_s;

`ifdef OCC_CTRL_SYNC_EN
  occ_sync u_sync_a (.clk(clk), .rst_n(rst_n), .d(sens_a), .q(a_s));
  occ_sync u_sync_b (.clk(clk), .rst_n(rst_n), .d(sens_b), .q(b_s));
`else
  assign a_s = sens_a;
  assign b_s = sens_b;
`endif

  logic [2:0]       state, seq_nxt, state_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             commit_en, commit_ex, timed_out;
  logic [CNT_W-1:0] occ_nxt;
  logic             add_nxt, del_nxt, load_nxt, rej_nxt, abort_nxt;

  // Sensor-driven sequencing only; clear/timeout overrides are applied below.
  always_comb begin
    seq_nxt   = state;
    commit_en = 1'b0;
    commit_ex = 1'b0;
    case (state)
      ST_IDLE: begin
        if ({a_s, b_s} == 2'b10)      seq_nxt = ST_EN1;
        else if ({a_s, b_s} == 2'b01) seq_nxt = ST_EX1;
      end
      ST_EN1: begin
        if ({a_s, b_s} == 2'b11)      seq_nxt = ST_EN2;
        else if (!a_s)                seq_nxt = ST_IDLE;
      end
      ST_EN2: begin
        if ({a_s, b_s} == 2'b01)      seq_nxt = ST_EN3;
        else if ({a_s, b_s} == 2'b10) seq_nxt = ST_EN1;
        else if ({a_s, b_s} == 2'b00) seq_nxt = ST_IDLE;
      end
      ST_EN3: begin
        if ({a_s, b_s} == 2'b00) begin
          seq_nxt   = ST_IDLE;
          commit_en = 1'b1;
        end
        else if ({a_s, b_s} == 2'b11) seq_nxt = ST_EN2;
        else if ({a_s, b_s} == 2'b10) seq_nxt = ST_IDLE;
      end
      ST_EX1: begin
        if ({a_s, b_s} == 2'b11)      seq_nxt = ST_EX2;
        else if (!b_s)                seq_nxt = ST_IDLE;
      end
      ST_EX2: begin
        if ({a_s, b_s} == 2'b10)      seq_nxt = ST_EX3;
        else if ({a_s, b_s} == 2'b01) seq_nxt = ST_EX1;
        else if ({a_s, b_s} == 2'b00) seq_nxt = ST_IDLE;
      end
      ST_EX3: begin
        if ({a_s, b_s} == 2'b00) begin
          seq_nxt   = ST_IDLE;
          commit_ex = 1'b1;
        end
        else if ({a_s, b_s} == 2'b11) seq_nxt = ST_EX2;
        else if ({a_s, b_s} == 2'b01) seq_nxt = ST_IDLE;
      end
      default: seq_nxt = ST_IDLE;
    endcase
  end

  // A commit always changes state, so it can never coincide with a timeout.
  assign timed_out = (state != ST_IDLE) && (seq_nxt == state) &&
                     (tmo_cnt == TMO_W'(TIMEOUT));

  always_comb begin
    state_nxt = seq_nxt;
    tmo_nxt   = '0;
    occ_nxt   = occupancy;
    add_nxt   = 1'b0;
    del_nxt   = 1'b0;
    load_nxt  = 1'b0;
    rej_nxt   = 1'b0;
    abort_nxt = 1'b0;
    if (clear) begin
      // Wins over any same-cycle commit; the dropped commit is not a reject.
      state_nxt = ST_IDLE;
      occ_nxt   = '0;
      load_nxt  = 1'b1;
    end else if (timed_out) begin
      state_nxt = ST_IDLE;
      abort_nxt = 1'b1;
    end else begin
      if (state != ST_IDLE && seq_nxt == state) tmo_nxt = tmo_cnt + TMO_W'(1);
      if (commit_en) begin
        if (occupancy < CNT_W'(CAPACITY)) begin
          add_nxt = 1'b1;
          occ_nxt = occupancy + CNT_W'(1);
        end else begin
          rej_nxt = 1'b1;
        end
      end
      if (commit_ex) begin
        if (occupancy != '0) begin
          del_nxt = 1'b1;
          occ_nxt = occupancy - CNT_W'(1);
        end else begin
          rej_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      occupancy <= '0;
      add       <= 1'b0;
      delete    <= 1'b0;
      load      <= 1'b0;
      reject    <= 1'b0;
      abort     <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
      gate_open <= 1'b1;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_nxt;
      occupancy <= occ_nxt;
      add       <= add_nxt;
      delete    <= del_nxt;
      load      <= load_nxt;
      reject    <= rej_nxt;
      abort     <= abort_nxt;
      full      <= (occ_nxt == CNT_W'(CAPACITY));
      empty     <= (occ_nxt == '0);
      gate_open <= (occ_nxt != CNT_W'(CAPACITY));
    end
  end

endmodule
